// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding
// and the load/store access-size encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Generic 2:1 steering mux used throughout the codebase.
module mux #(
  parameter int N = 32
) (
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic         sel,
  output logic [N-1:0] out
);

  assign out = sel ? i1 : i0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between fetch (I) and load/store (D).
// D has priority; a burst counter forces an I grant after MAX_D_BURST straight D grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel,
  output logic              if_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

  state_t           state_r;
  logic             sel_r;
  logic [CNT_W-1:0] burst_cnt_r;
  logic             grant_d_s;
  logic             grant_i_s;

  // Grant decision, only taken from IDLE; D loses only when fetch has been starved.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_req && !(if_req && (burst_cnt_r == CNT_MAX))) begin
        grant_d_s = 1'b1;
      end else if (if_req) begin
        grant_i_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Access sequencer, steering select and fetch-starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sel_r       <= 1'b0;
      burst_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            state_r <= BUSY_D;
            sel_r   <= 1'b1;
          end else if (grant_i_s) begin
            state_r <= BUSY_I;
            sel_r   <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
          sel_r   <= 1'b0;
        end
      endcase

      // Count only D grants that actually made fetch wait.
      if (!if_req || grant_i_s) begin
        burst_cnt_r <= '0;
      end else if (grant_d_s && (burst_cnt_r != CNT_MAX)) begin
        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end
  end

  mux #(.N(ADDR_W)) u_addr_mux (
    .i0  (if_addr),
    .i1  (d_addr),
    .sel (sel_r),
    .out (mem_addr)
  );

  assign sel       = sel_r;
  assign mem_req   = (state_r != IDLE);
  assign mem_we    = (state_r == BUSY_D) & d_we;
  assign mem_size  = sel_r ? d_size : SZ_WORD;
  assign mem_wdata = d_wdata;
  assign if_done   = (state_r == BUSY_I) & mem_ready;
  assign d_done    = (state_r == BUSY_D) & mem_ready;
  assign rdata     = mem_rdata;

endmodule
